signal_capture: RTL and testbench
=================================

# signal_capture

Triggered sample-capture buffer on the filtered-signal path. It records the 8-bit signed FIR output into an internal circular RAM around a rising threshold crossing, keeping a programmable number of pre-trigger samples. After capture it freezes the buffer so the window can be read back, oldest sample first, over a simple address/read-enable port. It is the consumer-side counterpart of the signal generator and sits after `filtro_fir`, in place of external probing.

## Interface
- `NB_DATA`, 8: sample width, two's complement.
- `ADDR_W`, 6: buffer address width; `DEPTH` = 2^`ADDR_W` = 64.
- `PRE_TRIG`, 16: samples kept before the trigger sample; legal range 1..`DEPTH`-1.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `i_srst` in 1: reset, synchronous and active-high.
- `i_en` in 1: sample strobe; `i_data` is accepted on cycles with `i_en`=1.
- `i_data` in `NB_DATA`: signed sample from the FIR.
- `i_threshold` in `NB_DATA`: signed trigger level; sampled every cycle.
- `i_arm` in 1: one-cycle pulse that starts or restarts a capture.
- `i_rd_en` in 1: read request.
- `i_rd_addr` in `ADDR_W`: read index relative to the oldest captured sample.
- `o_rd_data` out `NB_DATA`: read data.
- `o_rd_valid` out 1: marks `o_rd_data` valid.
- `o_armed` out 1: high in PRE, WAIT and POST.
- `o_triggered` out 1: high from trigger until re-arm or reset.
- `o_done` out 1: high in DONE.
- `o_trig_addr` out `ADDR_W`: physical RAM address of the trigger sample.

## Operation
FSM states: IDLE, PRE, WAIT, POST, DONE.

- **Reset:** state IDLE; write pointer, counters, `prev_valid`, `o_trig_addr` and all outputs = 0. RAM contents are not cleared.
- **`i_arm` from any state:**
  - next state is PRE;
  - write pointer, sample counter, `o_trig_addr` and `prev_valid` are cleared;
  - `o_triggered` is cleared;
  - `i_arm` has priority over every other event in the same cycle (read, trigger, sample write).
- **PRE:**
  - each accepted sample is written at the write pointer, then the pointer increments mod `DEPTH`;
  - after `PRE_TRIG` accepted samples, go to WAIT.
- **WAIT:**
  - writing continues circularly;
  - trigger condition: `prev_valid` && `prev` < `i_threshold` && `i_data` >= `i_threshold` (signed compare);
  - `prev` and `prev_valid` update on every accepted sample in PRE and WAIT;
  - on trigger, the trigger sample is written, `o_trig_addr` = its address, and the state goes to POST with a remaining count of `DEPTH`-`PRE_TRIG`-1;
  - a constant input level at or above the threshold never triggers.
- **POST:**
  - writing continues, decrementing the remaining count per sample;
  - the accepted sample that brings the count to 0 is the last one written, then go to DONE;
  - if `PRE_TRIG` = `DEPTH`-1, the count is already 0 and the state goes straight from the trigger to DONE.
- **DONE:**
  - no writes;
  - reads use physical address = (`o_trig_addr` - `PRE_TRIG` + `i_rd_addr`) mod `DEPTH`;
  - index `PRE_TRIG` is the trigger sample;
  - index 0 is the oldest sample, index `DEPTH`-1 the newest.
- **Reads:** honoured only in DONE. In any other state `o_rd_valid` = 0 and `o_rd_data` holds its previous value.
- **`i_en` = 0:** no write, no pointer or counter change, no update of `prev`.

## Timing
- Write: the sample is in RAM on the edge where `i_en`=1 is sampled.
- `o_triggered`: rises on the edge that accepts the trigger sample (registered).
- `o_done`: rises on the edge that writes the last POST sample.
- `o_armed`: high the cycle after `i_arm`; low the cycle after entering DONE.
- Read latency is 1 cycle: `i_rd_en` at cycle n gives `o_rd_valid`=1 and data at n+1.
- Back-to-back reads sustain one result per cycle.
- Reset mid-capture: IDLE on the next edge and all outputs 0. Any `i_arm` in that same cycle is ignored.

## Configuration
- `SIGNAL_CAPTURE_FORCE_TRIG_EN` defined:
  - adds input port `i_force_trig` (1 bit);
  - in WAIT, the next accepted sample with `i_force_trig`=1 is treated as the trigger sample, regardless of threshold or `prev_valid`.
- Undefined: the port does not exist and only the threshold crossing triggers.

## Test plan
- **Full ramp capture:** reset, pulse `i_arm`, `i_threshold`=0x00, then `i_data` ramps -128..127 with `i_en`=1 continuously.
  - Trigger on the value 0x00, `o_trig_addr`=0.
  - `o_done` after 47 further samples.
  - Reads return 0xF0 at index 0, 0x00 at index 16, 0x2F at index 63.
- **No crossing:** constant `i_data`=0x50 with `i_threshold`=0x40 for 500 cycles after arm → `o_armed`=1, `o_triggered`=0, `o_done`=0 throughout.
- **Gapped strobe:** same ramp as the full-ramp test, but `i_en` toggles 1/0 each cycle → identical readback values; `o_done` arrives about twice as late.
- **Re-arm during POST:** pulse `i_arm` 10 samples after trigger.
  - `o_triggered` drops next cycle, state returns to PRE.
  - A new ramp gives the same results as the full-ramp test.
- **Reset mid-operation and reads outside DONE:**
  - assert `i_srst` during WAIT → all outputs 0 next cycle;
  - `i_rd_en` in IDLE → `o_rd_valid` stays 0.
- **Forced trigger (macro defined):** flat input 0x10, `i_threshold`=0x7F, `i_force_trig` pulsed in WAIT → trigger on the next accepted sample and `o_done` after 47 more samples.

Source files
------------

// File: rtl/signal_capture_if.sv
// signal_capture_if
//   Groups the sample, trigger-control and read-back signals of
//   signal_capture. The clock and reset stay plain ports on the module.
//
//   master : drives the sample stream, arm, threshold and read requests
//   slave  : the capture buffer itself
//
//   Signals
//     i_en, i_data        sample strobe and signed sample
//     i_threshold         signed trigger level
//     i_arm               start / restart a capture
//     i_rd_en, i_rd_addr  read request, index relative to the oldest sample
//     o_rd_data/valid     registered read result
//     o_armed, o_triggered, o_done, o_trig_addr   capture status
//     i_force_trig        only with SIGNAL_CAPTURE_FORCE_TRIG_EN defined
interface signal_capture_if #(
    parameter int NB_DATA = 8,
    parameter int ADDR_W  = 6
);
    logic               i_en;
    logic [NB_DATA-1:0] i_data;
    logic [NB_DATA-1:0] i_threshold;
    logic               i_arm;
    logic               i_rd_en;
    logic [ADDR_W-1:0]  i_rd_addr;
    logic [NB_DATA-1:0] o_rd_data;
    logic               o_rd_valid;
    logic               o_armed;
    logic               o_triggered;
    logic               o_done;
    logic [ADDR_W-1:0]  o_trig_addr;
`ifdef SIGNAL_CAPTURE_FORCE_TRIG_EN
    logic               i_force_trig;
`endif

    modport master (
        output i_en, i_data, i_threshold, i_arm, i_rd_en, i_rd_addr,
`ifdef SIGNAL_CAPTURE_FORCE_TRIG_EN
        output i_force_trig,
`endif
        input  o_rd_data, o_rd_valid, o_armed, o_triggered, o_done, o_trig_addr
    );

    modport slave (
        input  i_en, i_data, i_threshold, i_arm, i_rd_en, i_rd_addr,
`ifdef SIGNAL_CAPTURE_FORCE_TRIG_EN
        input  i_force_trig,
`endif
        output o_rd_data, o_rd_valid, o_armed, o_triggered, o_done, o_trig_addr
    );
endinterface

// File: rtl/signal_capture.sv
// signal_capture
//   Triggered capture buffer for the FIR output. Samples are written into a
//   circular RAM; once PRE_TRIG samples are stored, a rising crossing of
//   i_threshold (prev < thr <= current, signed) marks the trigger sample.
//   Capture continues until the RAM holds DEPTH-PRE_TRIG-1 post-trigger
//   samples, then the buffer freezes and may be read oldest-first.
//
//   Ports
//     clk     rising-edge clock
//     i_srst  synchronous active-high reset
//     bus     signal_capture_if.slave (sample stream, arm, reads, status)
//
//   Optional feature macro: SIGNAL_CAPTURE_FORCE_TRIG_EN
//     adds bus.i_force_trig; in WAIT an accepted sample with it high is the
//     trigger sample regardless of the threshold.
module signal_capture #(
    parameter int NB_DATA  = 8,
    parameter int ADDR_W   = 6,
    parameter int PRE_TRIG = 16
) (
    input  logic clk,
    input  logic i_srst,
    signal_capture_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] PRE_OFF  = ADDR_W'(PRE_TRIG);
    localparam logic [ADDR_W-1:0] PRE_LAST = ADDR_W'(PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] POST_LEN = ADDR_W'(DEPTH - PRE_TRIG - 1);

    generate
        if (PRE_TRIG < 1 || PRE_TRIG > DEPTH - 1) begin : g_bad_pre_trig
            $error("signal_capture: PRE_TRIG out of range 1..DEPTH-1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT,
        ST_POST,
        ST_DONE
    } state_t;

    state_t state, next_state;

    logic [NB_DATA-1:0] ram [DEPTH];

    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  cnt;          // PRE: samples stored; POST: samples left
    logic [NB_DATA-1:0] prev;
    logic               prev_valid;
    logic [ADDR_W-1:0]  trig_addr;
    logic               triggered;
    logic [NB_DATA-1:0] rd_data;
    logic               rd_valid;

    logic               wr_en;
    logic               trig_hit;
    logic               rd_hit;
    logic               crossing;
    logic               trig_cond;
    logic [ADDR_W-1:0]  rd_phys;

    // Oldest stored sample sits PRE_TRIG slots before the trigger sample;
    // the subtraction wraps naturally at ADDR_W bits.
    assign rd_phys = trig_addr - PRE_OFF + bus.i_rd_addr;

    assign crossing = prev_valid
                   && ($signed(prev) < $signed(bus.i_threshold))
                   && ($signed(bus.i_data) >= $signed(bus.i_threshold));

`ifdef SIGNAL_CAPTURE_FORCE_TRIG_EN
    assign trig_cond = crossing || bus.i_force_trig;
`else
    assign trig_cond = crossing;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (i_srst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and per-cycle control. i_arm overrides every other event.
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        trig_hit   = 1'b0;
        rd_hit     = 1'b0;
        if (bus.i_arm) begin
            next_state = ST_PRE;
        end else begin
            case (state)
                ST_IDLE: begin
                end
                ST_PRE: begin
                    if (bus.i_en) begin
                        wr_en = 1'b1;
                        if (cnt == PRE_LAST) begin
                            next_state = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.i_en) begin
                        wr_en = 1'b1;
                        if (trig_cond) begin
                            trig_hit   = 1'b1;
                            // With PRE_TRIG = DEPTH-1 nothing follows the trigger.
                            next_state = (POST_LEN == '0) ? ST_DONE : ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (bus.i_en) begin
                        wr_en = 1'b1;
                        if (cnt == ADDR_W'(1)) begin
                            next_state = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    rd_hit = bus.i_rd_en;
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sample RAM (no reset: contents survive reset and re-arm)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en && !i_srst) begin
            ram[wr_ptr] <= bus.i_data;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (i_srst) begin
            wr_ptr     <= '0;
            cnt        <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            trig_addr  <= '0;
            triggered  <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
        end else if (bus.i_arm) begin
            wr_ptr     <= '0;
            cnt        <= '0;
            prev_valid <= 1'b0;
            trig_addr  <= '0;
            triggered  <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            rd_valid <= rd_hit;
            if (rd_hit) begin
                rd_data <= ram[rd_phys];
            end

            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end

            if (wr_en && (state == ST_PRE || state == ST_WAIT)) begin
                prev       <= bus.i_data;
                prev_valid <= 1'b1;
            end

            case (state)
                ST_PRE: begin
                    if (bus.i_en) begin
                        cnt <= (cnt == PRE_LAST) ? '0 : cnt + ADDR_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (trig_hit) begin
                        cnt       <= POST_LEN;
                        trig_addr <= wr_ptr;
                        triggered <= 1'b1;
                    end
                end
                ST_POST: begin
                    if (bus.i_en) begin
                        cnt <= cnt - ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.o_rd_data   = rd_data;
    assign bus.o_rd_valid  = rd_valid;
    assign bus.o_armed     = (state == ST_PRE) || (state == ST_WAIT) || (state == ST_POST);
    assign bus.o_triggered = triggered;
    assign bus.o_done      = (state == ST_DONE);
    assign bus.o_trig_addr = trig_addr;

endmodule

// File: tb/tb_signal_capture.sv
// tb_signal_capture
//   Directed bench for signal_capture (NB_DATA=8, ADDR_W=6, PRE_TRIG=16).
//   Inputs change 1 time unit after the rising edge; outputs are examined
//   at that same point, i.e. well away from the next active edge.
module tb_signal_capture;

    logic clk;
    logic i_srst;

    int n_checks;
    int n_errors;

    signal_capture_if #(.NB_DATA(8), .ADDR_W(6)) bus ();

    signal_capture #(
        .NB_DATA (8),
        .ADDR_W  (6),
        .PRE_TRIG(16)
    ) dut (
        .clk   (clk),
        .i_srst(i_srst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed the ramp -128..last_v, optionally with an idle cycle after each
    // sample. Reports the ramp value seen as trigger, the number of samples
    // after it up to o_done, and the clock cycles over that span.
    task automatic capture_ramp(input bit do_arm, input bit gapped, input int last_v,
                                output int trig_v, output int done_after,
                                output int done_cycles);
        int  cyc;
        bit  tseen;
        trig_v      = 999;
        done_after  = -1;
        done_cycles = -1;
        tseen       = 1'b0;
        cyc         = 0;
        if (do_arm) begin
            bus.i_arm = 1'b1;
            tick();
            bus.i_arm = 1'b0;
        end
        for (int v = -128; v <= last_v; v++) begin
            bus.i_data = 8'(v);
            bus.i_en   = 1'b1;
            tick();
            cyc++;
            if (bus.o_triggered && !tseen) begin
                tseen  = 1'b1;
                trig_v = v;
                cyc    = 0;
            end
            if (bus.o_done && done_after < 0) begin
                done_after  = v - trig_v;
                done_cycles = cyc;
            end
            if (gapped) begin
                bus.i_en   = 1'b0;
                bus.i_data = 8'h7F;   // would block the crossing if it leaked into prev
                tick();
                cyc++;
            end
        end
        bus.i_en = 1'b0;
    endtask

    // Full window readback, back-to-back. Window index i holds ramp value i-16.
    task automatic read_window(input string tag);
        logic [7:0] exp_d;
        for (int i = 0; i < 64; i++) begin
            bus.i_rd_en   = 1'b1;
            bus.i_rd_addr = 6'(i);
            tick();
            exp_d = 8'(i - 16);
            check_eq({tag, "_valid"}, 32'(bus.o_rd_valid), 32'd1);
            check_eq({tag, "_data"}, 32'(bus.o_rd_data), 32'(exp_d));
        end
        bus.i_rd_en = 1'b0;
        tick();
        check_eq({tag, "_valid_off"}, 32'(bus.o_rd_valid), 32'd0);
        check_eq({tag, "_hold"}, 32'(bus.o_rd_data), 32'h2F);
    endtask

    task automatic read_one(input string tag, input int idx, input logic [7:0] exp_d);
        bus.i_rd_en   = 1'b1;
        bus.i_rd_addr = 6'(idx);
        tick();
        bus.i_rd_en = 1'b0;
        check_eq({tag, "_valid"}, 32'(bus.o_rd_valid), 32'd1);
        check_eq(tag, 32'(bus.o_rd_data), 32'(exp_d));
    endtask

    task automatic check_ramp(input string tag, input int trig_v, input int done_after,
                              input int done_cycles, input int exp_cycles);
        check_eq({tag, "_trig_value"}, 32'(trig_v), 32'd0);
        check_eq({tag, "_trig_addr"}, 32'(bus.o_trig_addr), 32'd0);
        check_eq({tag, "_done_after"}, 32'(done_after), 32'd47);
        check_eq({tag, "_done_cycles"}, 32'(done_cycles), 32'(exp_cycles));
        check_eq({tag, "_done"}, 32'(bus.o_done), 32'd1);
        check_eq({tag, "_armed"}, 32'(bus.o_armed), 32'd0);
        check_eq({tag, "_triggered"}, 32'(bus.o_triggered), 32'd1);
        read_one({tag, "_idx0"}, 0, 8'hF0);
        read_one({tag, "_idx16"}, 16, 8'h00);
        read_one({tag, "_idx63"}, 63, 8'h2F);
        read_window(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_armed"}, 32'(bus.o_armed), 32'd0);
        check_eq({tag, "_triggered"}, 32'(bus.o_triggered), 32'd0);
        check_eq({tag, "_done"}, 32'(bus.o_done), 32'd0);
        check_eq({tag, "_trig_addr"}, 32'(bus.o_trig_addr), 32'd0);
        check_eq({tag, "_rd_valid"}, 32'(bus.o_rd_valid), 32'd0);
        check_eq({tag, "_rd_data"}, 32'(bus.o_rd_data), 32'd0);
    endtask

    initial begin
        int trig_v, done_after, done_cycles, bad;
        n_checks = 0;
        n_errors = 0;
        i_srst          = 1'b1;
        bus.i_en        = 1'b0;
        bus.i_data      = '0;
        bus.i_threshold = '0;
        bus.i_arm       = 1'b0;
        bus.i_rd_en     = 1'b0;
        bus.i_rd_addr   = '0;
`ifdef SIGNAL_CAPTURE_FORCE_TRIG_EN
        bus.i_force_trig = 1'b0;
`endif
        tick();
        tick();
        i_srst = 1'b0;
        check_all_zero("reset");

        // Reads outside DONE are ignored.
        bus.i_rd_en = 1'b1;
        tick();
        check_eq("idle_read_valid", 32'(bus.o_rd_valid), 32'd0);
        bus.i_rd_en = 1'b0;

        // Full ramp capture.
        bus.i_threshold = 8'h00;
        capture_ramp(1'b1, 1'b0, 127, trig_v, done_after, done_cycles);
        check_ramp("ramp", trig_v, done_after, done_cycles, 47);

        // Gapped strobe: same window, twice the latency.
        capture_ramp(1'b1, 1'b1, 127, trig_v, done_after, done_cycles);
        check_ramp("gapped", trig_v, done_after, done_cycles, 94);

        // Re-arm during POST, 10 samples after the trigger. The sample
        // presented with i_arm must not be stored.
        capture_ramp(1'b1, 1'b0, 10, trig_v, done_after, done_cycles);
        check_eq("rearm_pre_triggered", 32'(bus.o_triggered), 32'd1);
        check_eq("rearm_pre_done", 32'(bus.o_done), 32'd0);
        bus.i_arm  = 1'b1;
        bus.i_en   = 1'b1;
        bus.i_data = 8'h55;
        tick();
        bus.i_arm = 1'b0;
        bus.i_en  = 1'b0;
        check_eq("rearm_triggered", 32'(bus.o_triggered), 32'd0);
        check_eq("rearm_armed", 32'(bus.o_armed), 32'd1);
        check_eq("rearm_done", 32'(bus.o_done), 32'd0);
        capture_ramp(1'b0, 1'b0, 127, trig_v, done_after, done_cycles);
        check_ramp("rearm_ramp", trig_v, done_after, done_cycles, 47);

        // No crossing: level stays above threshold.
        bus.i_threshold = 8'h40;
        bus.i_arm = 1'b1;
        tick();
        bus.i_arm = 1'b0;
        bad = 0;
        bus.i_data = 8'h50;
        bus.i_en   = 1'b1;
        for (int c = 0; c < 500; c++) begin
            tick();
            if (bus.o_armed !== 1'b1 || bus.o_triggered !== 1'b0 || bus.o_done !== 1'b0)
                bad++;
        end
        bus.i_en = 1'b0;
        check_eq("nocross_bad_cycles", 32'(bad), 32'd0);

        // Reset in WAIT together with i_arm: reset wins, i_arm ignored.
        bus.i_threshold = 8'h00;
        bus.i_arm = 1'b1;
        tick();
        bus.i_arm  = 1'b0;
        bus.i_data = 8'h9C;
        bus.i_en   = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        bus.i_en = 1'b0;
        check_eq("wait_armed", 32'(bus.o_armed), 32'd1);
        check_eq("wait_triggered", 32'(bus.o_triggered), 32'd0);
        bus.i_rd_en = 1'b1;
        tick();
        check_eq("wait_read_valid", 32'(bus.o_rd_valid), 32'd0);
        check_eq("wait_read_hold", 32'(bus.o_rd_data), 32'h2F);
        bus.i_rd_en = 1'b0;
        i_srst    = 1'b1;
        bus.i_arm = 1'b1;
        tick();
        i_srst    = 1'b0;
        bus.i_arm = 1'b0;
        check_all_zero("midreset");
        tick();
        check_eq("midreset_arm_ignored", 32'(bus.o_armed), 32'd0);

`ifdef SIGNAL_CAPTURE_FORCE_TRIG_EN
        // Forced trigger on a flat input that never crosses.
        bus.i_threshold = 8'h7F;
        bus.i_arm = 1'b1;
        tick();
        bus.i_arm  = 1'b0;
        bus.i_data = 8'h10;
        bus.i_en   = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        check_eq("force_pre_triggered", 32'(bus.o_triggered), 32'd0);
        bus.i_force_trig = 1'b1;
        tick();
        bus.i_force_trig = 1'b0;
        check_eq("force_triggered", 32'(bus.o_triggered), 32'd1);
        check_eq("force_trig_addr", 32'(bus.o_trig_addr), 32'd20);
        done_after = -1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (bus.o_done && done_after < 0) done_after = c;
        end
        bus.i_en = 1'b0;
        check_eq("force_done_after", 32'(done_after), 32'd47);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
